// File: rtl/demux_pkg.sv
// Shared defaults, index width and state encoding for the byte-to-word unstriper.
package demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LANES  = 4;
  localparam int IDX_W      = $clog2(DEF_LANES);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

endpackage

// File: rtl/demux_lane_reg.sv
// One lane byte register with load enable and synchronous active-high clear.
module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clkf,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clkf) begin
    if (clr)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/demux1a4_unstripe.sv
// Gathers a valid-qualified byte stream into LANES-wide words with a valid/ready output.
// Optional saturating sop-realign drop counter is built when DEMUX_ERRCNT_EN is defined.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_FILL | collecting lanes into staging; in_ready high
//   ST_FULL | staging complete, output register still occupied; in_ready low
module demux1a4_unstripe
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic                    clkf,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_sop,
  output logic                    in_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              err_cnt
);

  localparam int            IW       = $clog2(LANES);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  state_t            state, state_nx;
  logic [IW-1:0]     lane_idx, lane_idx_nx;
  logic [IW-1:0]     wr_idx;
  logic              out_valid_r, out_valid_nx;
  logic              accept, last_lane, out_free;
  logic              out_load, out_from_in;
  logic [LANES-1:0]  stg_load;
  logic [DATA_W-1:0] stg_q [LANES];
  logic [DATA_W-1:0] out_d [LANES];
  logic [DATA_W-1:0] out_q [LANES];

  assign in_ready  = (state == ST_FILL);
  assign out_valid = out_valid_r;

  always_comb begin
    accept    = in_valid && (state == ST_FILL);
    wr_idx    = in_sop ? '0 : lane_idx;
    last_lane = accept && (wr_idx == LAST_IDX);
    out_free  = !out_valid_r || out_ready;
  end

  always_ff @(posedge clkf) begin
    if (reset) begin
      state       <= ST_FILL;
      lane_idx    <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state       <= state_nx;
      lane_idx    <= lane_idx_nx;
      out_valid_r <= out_valid_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    lane_idx_nx  = lane_idx;
    out_valid_nx = out_valid_r;
    out_load     = 1'b0;
    out_from_in  = 1'b0;

    if (accept)
      lane_idx_nx = in_sop ? IW'(1) : lane_idx + IW'(1);
    if (out_valid_r && out_ready)
      out_valid_nx = 1'b0;

    case (state)
      ST_FILL: begin
        if (last_lane) begin
          if (out_free) begin
            // Bypass the final byte straight into the output word so the
            // word is visible one cycle after its last lane is accepted.
            out_load     = 1'b1;
            out_from_in  = 1'b1;
            out_valid_nx = 1'b1;
          end else begin
            state_nx = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (out_free) begin
          out_load     = 1'b1;
          out_valid_nx = 1'b1;
          state_nx     = ST_FILL;
        end
      end
      default: state_nx = ST_FILL;
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign stg_load[k] = accept && (wr_idx == IW'(k));
    assign out_d[k]    = (out_from_in && (wr_idx == IW'(k))) ? in_data : stg_q[k];

    demux_lane_reg #(.DATA_W(DATA_W)) u_stg (
      .clkf (clkf),
      .clr  (reset),
      .load (stg_load[k]),
      .d    (in_data),
      .q    (stg_q[k])
    );

    demux_lane_reg #(.DATA_W(DATA_W)) u_out (
      .clkf (clkf),
      .clr  (reset),
      .load (out_load),
      .d    (out_d[k]),
      .q    (out_q[k])
    );

    assign out_data[k*DATA_W +: DATA_W] = out_q[k];
  end

`ifdef DEMUX_ERRCNT_EN
  logic       drop;
  logic [7:0] err_q;

  // A realigning sop only loses data when a word was already partly filled.
  assign drop = accept && in_sop && (lane_idx != '0);

  always_ff @(posedge clkf) begin
    if (reset)                      err_q <= 8'd0;
    else if (drop && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_demux1a4_unstripe.sv
// Directed-vector bench for demux1a4_unstripe; expected err_cnt follows DEMUX_ERRCNT_EN.
module tb_demux1a4_unstripe;

`ifdef DEMUX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic        clkf = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clkf = ~clkf;

  demux1a4_unstripe dut (
    .clkf      (clkf),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkf);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sop);
    in_data  = d;
    in_valid = 1'b1;
    in_sop   = sop;
    tick();
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"},  out_data,  32'h0);
    chk({tag, "_err_cnt"},   err_cnt,   8'h00);
  endtask

  logic [31:0] exp_w [4];

  initial begin
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // 1: single word, visible for exactly one cycle
    send(8'hA0, 1'b1);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    chk("t1_not_yet", out_valid, 1'b0);
    send(8'hA3, 1'b0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data",  out_data,  32'hA3A2A1A0);
    idle();
    chk("t1_one_cycle", out_valid, 1'b0);

    // 2: 16 bytes back-to-back
    exp_w[0] = 32'hB3B2B1B0;
    exp_w[1] = 32'hB7B6B5B4;
    exp_w[2] = 32'hBBBAB9B8;
    exp_w[3] = 32'hBFBEBDBC;
    for (int i = 0; i < 16; i++) begin
      chk("t2_in_ready", in_ready, 1'b1);
      send(8'hB0 + 8'(i), (i % 4) == 0);
      if ((i % 4) == 3) begin
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_data",  out_data,  exp_w[i/4]);
      end
    end
    idle();

    // 3: backpressure into FULL, then release
    out_ready = 1'b0;
    send(8'hC0, 1'b1);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    chk("t3_w0_valid", out_valid, 1'b1);
    chk("t3_w0_data",  out_data,  32'hC3C2C1C0);
    send(8'hC4, 1'b0);
    send(8'hC5, 1'b0);
    chk("t3_w0_stable", out_data, 32'hC3C2C1C0);
    chk("t3_fill_ready", in_ready, 1'b1);
    send(8'hC6, 1'b0);
    send(8'hC7, 1'b0);
    chk("t3_full_ready", in_ready, 1'b0);
    idle();
    idle();
    chk("t3_full_hold_ready", in_ready,  1'b0);
    chk("t3_full_hold_valid", out_valid, 1'b1);
    chk("t3_full_hold_data",  out_data,  32'hC3C2C1C0);
    out_ready = 1'b1;
    tick();
    chk("t3_w1_valid", out_valid, 1'b1);
    chk("t3_w1_data",  out_data,  32'hC7C6C5C4);
    chk("t3_w1_ready", in_ready,  1'b1);
    tick();
    chk("t3_drained", out_valid, 1'b0);

    // 4: sop realign drops the partial 11,22
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    chk("t4_no_early_word", out_valid, 1'b0);
    send(8'h66, 1'b0);
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_data",  out_data,  32'h66554433);
    chk("t4_err",   err_cnt,   ERRCNT ? 8'd1 : 8'd0);
    idle();

    // 5: reset mid-word, then reset while FULL
    send(8'hD0, 1'b1);
    send(8'hD1, 1'b0);
    reset = 1'b1;
    tick();
    chk_reset_vals("t5a");
    reset = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'hE0 + 8'(i), i == 0);
    chk("t5_in_full", in_ready, 1'b0);
    reset = 1'b1;
    tick();
    chk_reset_vals("t5b");
    reset = 1'b0;
    out_ready = 1'b1;
    send(8'hF0, 1'b0);
    send(8'hF1, 1'b0);
    send(8'hF2, 1'b0);
    send(8'hF3, 1'b0);
    chk("t5_clean_valid", out_valid, 1'b1);
    chk("t5_clean_data",  out_data,  32'hF3F2F1F0);
    idle();

    // 6: 300 realign drops; first sop starts at lane 0 and drops nothing
    for (int i = 0; i < 255; i++) send(8'h5A, 1'b1);
    chk("t6_err_254", err_cnt, ERRCNT ? 8'hFE : 8'h00);
    send(8'h5A, 1'b1);
    chk("t6_err_255", err_cnt, ERRCNT ? 8'hFF : 8'h00);
    for (int i = 0; i < 45; i++) send(8'h5A, 1'b1);
    chk("t6_err_sat", err_cnt, ERRCNT ? 8'hFF : 8'h00);
    chk("t6_in_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
